cic_comp_fir: RTL

Programmable serial-MAC FIR compensation filter with decimate-by-2, placed directly downstream of the 3-stage PDM CIC decimator in each microphone channel. It accepts CIC output words through a valid/ready handshake, removes a fixed DC offset, and convolves the samples with a runtime-loadable coefficient set that flattens the CIC droop. It emits one signed, rounded and optionally saturated PCM sample for every two accepted inputs.

---
 rtl/cic_comp_fir.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC FIR compensation filter with decimate-by-2.
//
// Sits behind the PDM CIC decimator.
// - Each accepted word has IN_OFFSET removed and is shifted into a TAPS-deep
//   delay line.
// - Every second acceptance starts one multiply-accumulate pass, one tap per
//   cycle.
// - The pass result is rounded half-up from Q2.(COEF_W-2) and presented on
//   a valid/ready output.
//
// Optional feature macro: CICCOMP_SAT_EN
//   defined   -> output clamped to OUT_W signed range, out_sat flags clipping
//   undefined -> output is the low OUT_W bits (wrap), out_sat tied to 0
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_data/in_valid/in_ready      CIC sample input handshake
//   out_data/out_valid/out_ready   PCM sample output handshake
//   out_sat                        current out_data was clipped
//   coef_we/coef_addr/coef_data    coefficient write port (IDLE only)
//   coef_err                       one-cycle pulse on a rejected write
module cic_comp_fir #(
  parameter int IN_W      = 17,
  parameter int OUT_W     = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 16,
  parameter int IN_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat,
  input  logic              coef_we,
  input  logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err
);

  localparam int S_W    = IN_W + 1;
  localparam int PROD_W = S_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int CNT_W  = $clog2(TAPS + 1);
  localparam int SHIFT  = COEF_W - 2;

  // Unity gain in tap 0, all other taps zero.
  localparam logic [TAPS-1:0][COEF_W-1:0] COEF_RST = (TAPS*COEF_W)'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0]     RND      = ACC_W'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                       state_q, state_d;
  logic [TAPS-1:0][S_W-1:0]     dly_q, dly_d;
  logic [TAPS-1:0][COEF_W-1:0]  coef_q, coef_d;
  logic                         phase_q, phase_d;
  logic [CNT_W-1:0]             tap_q, tap_d;
  logic signed [PROD_W-1:0]     prod_q, prod_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [OUT_W-1:0]             out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;
  logic                         coef_err_q, coef_err_d;

  logic                         accept;
  logic                         coef_ok;
  logic [S_W-1:0]               s_in;
  logic [IDX_W-1:0]             tap_idx;

  assign accept   = in_valid && (state_q == S_IDLE);
  assign coef_ok  = (state_q == S_IDLE) && ({1'b0, coef_addr} < 7'(TAPS));
  assign s_in     = S_W'(in_data) - S_W'(IN_OFFSET);
  assign tap_idx  = tap_q[IDX_W-1:0];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign coef_err  = coef_err_q;

`ifdef CICCOMP_SAT_EN
  logic signed [ACC_W-1:0]   y;
  logic [ACC_W-OUT_W:0]      y_hi;
  assign y    = (acc_q + RND) >>> SHIFT;
  assign y_hi = y[ACC_W-1:OUT_W-1];
`endif

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    coef_d     = coef_q;
    phase_d    = phase_q;
    tap_d      = tap_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    coef_err_d = coef_we && !coef_ok;

    // A write in the same IDLE cycle as a pair-completing acceptance lands
    // before the first product is formed, so the pass sees the new value.
    if (coef_we && coef_ok) coef_d[coef_addr[IDX_W-1:0]] = coef_data;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          dly_d   = {dly_q[TAPS-2:0], s_in};
          phase_d = ~phase_q;
          if (phase_q) begin
            acc_d   = '0;
            tap_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      // Multiply is registered, so accumulation trails it by one cycle and
      // the pass spans TAPS+1 cycles (tap_q = 0..TAPS).
      S_MAC: begin
        tap_d = tap_q + 1'b1;
        if (tap_q < CNT_W'(TAPS))
          prod_d = PROD_W'($signed(coef_q[tap_idx])) * PROD_W'($signed(dly_q[tap_idx]));
        else
          prod_d = '0;
        if (tap_q != '0) acc_d = acc_q + ACC_W'(prod_q);
        if (tap_q == CNT_W'(TAPS)) state_d = S_ROUND;
      end
      S_ROUND: begin
`ifdef CICCOMP_SAT_EN
        // Fits in OUT_W only if all bits from the OUT_W sign bit up agree.
        if (!(&y_hi) && (|y_hi)) begin
          out_data_d = y[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = y[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
`else
        out_data_d = OUT_W'((acc_q + RND) >>> SHIFT);
        out_sat_d  = 1'b0;
`endif
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dly_q      <= '0;
      coef_q     <= COEF_RST;
      phase_q    <= 1'b0;
      tap_q      <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      coef_q     <= coef_d;
      phase_q    <= phase_d;
      tap_q      <= tap_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      coef_err_q <= coef_err_d;
    end
  end

endmodule
